// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: state encoding, opcode class boundaries, defaults.
// Optional write-back phase is enabled by defining ALU_SEQ_WB_EN.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam int MUL_CYC_DEFAULT = 4;
    localparam int OPW_DEFAULT     = 4;
    localparam int CTR_W           = 4;

    localparam logic [3:0] OP_MULTI_BASE   = 4'h8;
    localparam logic [3:0] OP_ILLEGAL_BASE = 4'hC;

`ifdef ALU_SEQ_WB_EN
    localparam int NUM_PHASES = 4;
`else
    localparam int NUM_PHASES = 3;
`endif

    // The counter runs down to zero, so an N-cycle execute phase loads N-1.
    function automatic logic [CTR_W-1:0] exec_load_val(input logic multi, input int mul_cyc);
        return multi ? CTR_W'(mul_cyc - 1) : '0;
    endfunction

endpackage

// File: rtl/alu_seq_exec_ctr.sv
// Execute-phase down-counter: load, decrement, hold; last_o flags the final execute cycle.
module alu_seq_exec_ctr
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CTR_W-1:0] count_o,
    output logic             last_o
);

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving ALU select, start and write-enable strobes.
// Define ALU_SEQ_WB_EN to add a one-cycle write-back phase (state WB, output w).
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYC = MUL_CYC_DEFAULT,
    parameter int OPW     = OPW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    input  logic [OPW-1:0] instr_op,
    input  logic           hold,
    output logic           instr_ready,
    output logic           f,
    output logic           d,
    output logic           e,
`ifdef ALU_SEQ_WB_EN
    output logic           w,
`endif
    output logic [OPW-1:0] alu_sel,
    output logic           alu_start,
    output logic           reg_we,
    output logic           err,
    output logic           busy
);

    state_t           state_q;
    logic [OPW-1:0]   alu_sel_q;
    logic             started_q;

    logic             advance;
    logic             op_illegal;
    logic             op_multi;
    logic             ctr_load;
    logic             ctr_dec;
    logic             ctr_last;
    logic [CTR_W-1:0] ctr_load_val;
    logic [CTR_W-1:0] ctr_count;
    logic [NUM_PHASES-1:0] phase_vec;

    // Pulses and state moves only happen in cycles that are neither held nor in reset.
    assign advance    = !hold && !rst;
    assign op_illegal = (alu_sel_q >= OPW'(OP_ILLEGAL_BASE));
    assign op_multi   = (alu_sel_q >= OPW'(OP_MULTI_BASE)) && !op_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
            assign phase_vec[gi] = (state_q == state_t'(gi));
        end
    endgenerate

    assign f = phase_vec[ST_FETCH];
    assign d = phase_vec[ST_DECODE];
    assign e = phase_vec[ST_EXEC];
`ifdef ALU_SEQ_WB_EN
    assign w = phase_vec[ST_WB];
`endif

    assign ctr_load     = d && advance && !op_illegal;
    assign ctr_dec      = e && advance && !ctr_last;
    assign ctr_load_val = exec_load_val(op_multi, MUL_CYC);

    alu_seq_exec_ctr u_exec_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (ctr_load_val),
        .dec_i      (ctr_dec),
        .count_o    (ctr_count),
        .last_o     (ctr_last)
    );

    assign instr_ready = f && advance;
    assign busy        = !f;
    assign alu_sel     = alu_sel_q;
    assign err         = d && op_illegal && advance;
    // started_q keeps alu_start to one pulse even when the first execute cycle is held.
    assign alu_start   = e && !started_q && advance;
`ifdef ALU_SEQ_WB_EN
    assign reg_we      = w && advance;
`else
    assign reg_we      = e && ctr_last && advance;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            alu_sel_q <= '0;
            started_q <= 1'b0;
        end else if (!hold) begin
            case (state_q)
                ST_FETCH: begin
                    if (instr_valid) begin
                        alu_sel_q <= instr_op;
                        state_q   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    started_q <= 1'b0;
                    state_q   <= op_illegal ? ST_FETCH : ST_EXEC;
                end
                ST_EXEC: begin
                    started_q <= 1'b1;
                    if (ctr_last) begin
`ifdef ALU_SEQ_WB_EN
                        state_q <= ST_WB;
`else
                        state_q <= ST_FETCH;
`endif
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^ctr_count;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYC, default 4, execute-phase length in cycles for multi-cycle opcodes (legal range 2..16).
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  requester has an opcode on instr_op.
REQ-006 SHALL have port instr_op  input  OPW  opcode offered by requester.
REQ-007 SHALL have port hold  input  1  freeze request from downstream.
REQ-008 SHALL have port instr_ready  output  1  sequencer accepts instr_op this cycle.
REQ-009 SHALL have ports f, d, e  output  1 each  one-hot fetch/decode/execute phase strobes.
REQ-010 SHALL have port alu_sel  output  OPW  registered opcode driving the ALU select lines.
REQ-011 SHALL have ports alu_start, reg_we, err  output  1 each  single-cycle pulses: execute begin, result write enable, illegal opcode.
REQ-012 SHALL have port busy  output  1  high whenever state is not FETCH.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC (plus WB under ALU_SEQ_WB_EN); f/d/e (and w) one-hot, decoded from state.
REQ-014 FETCH: instr_ready = !hold && !rst; on instr_valid && instr_ready capture instr_op into alu_sel, next state DECODE; otherwise stay in FETCH.
REQ-015 DECODE: one cycle; opcodes 0x0-0xB legal -> EXEC; 0xC-0xF illegal -> err pulse this cycle, next state FETCH, no alu_start, no reg_we.
REQ-016 EXEC: alu_start pulses in first EXEC cycle only; opcodes 0x0-0x7 occupy 1 cycle, 0x8-0xB occupy exactly MUL_CYC cycles counted by a 4-bit down-counter loaded with MUL_CYC-1.
REQ-017 Without ALU_SEQ_WB_EN, reg_we pulses in the last EXEC cycle and next state is FETCH.
REQ-018 Single-cycle op latency SHALL be 3 cycles handshake-to-handshake (FETCH, DECODE, EXEC); back-to-back acceptance SHALL be possible in the FETCH cycle immediately after EXEC.
REQ-019 hold high SHALL freeze state, counter and alu_sel in any state; alu_start, reg_we, err suppressed while held; they fire in the first unheld cycle of the phase where they are due, exactly once.
REQ-020 alu_sel SHALL change only on a FETCH handshake; it holds the last accepted opcode otherwise.
REQ-021 instr_op SHALL be ignored when no handshake occurs; instr_valid may drop without penalty.

Reset
REQ-022 rst high at a clock edge SHALL force state FETCH, counter 0, alu_sel 0, regardless of current phase.
REQ-023 Post-reset outputs SHALL be: f=1, d=0, e=0, w=0, busy=0, alu_start=0, reg_we=0, err=0, alu_sel=0; instr_ready=0 while rst is high.
REQ-024 Reset mid-EXEC SHALL abandon the operation with no reg_we pulse.

Configuration
REQ-025 Macro ALU_SEQ_WB_EN defined: adds state WB and output w (1 bit); after the last EXEC cycle go WB for one cycle, reg_we pulses in WB (not EXEC), then FETCH; single-cycle latency becomes 4.
REQ-026 Macro ALU_SEQ_WB_EN undefined: no WB state, no w port, behaviour per REQ-017.

Structure
REQ-027 Package alu_seq_pkg SHALL hold the state encoding, opcode boundary constants (0x8 multi-cycle base, 0xC illegal base) and MUL_CYC default.
REQ-028 The execute-cycle counter SHALL be a sub-module alu_seq_exec_ctr (load, decrement, hold, last flag).

Verification
REQ-029 Reset, then instr_valid=1, op=0x3 -> instr_ready=1 cycle 0, d cycle 1, e+alu_start+reg_we cycle 2, f cycle 3, alu_sel=0x3.
REQ-030 op=0x9, MUL_CYC=4 -> e high 4 consecutive cycles, alu_start in first only, reg_we in fourth only.
REQ-031 op=0xE -> err pulse in DECODE cycle, no e, no reg_we, f next cycle.
REQ-032 op=0x8 with hold high for 3 cycles at EXEC cycle 2 -> e held 7 cycles total, single reg_we, counter resumes from frozen value.
REQ-033 rst asserted in EXEC cycle 2 of op=0xA -> next cycle f=1, alu_sel=0, no reg_we ever for that op.
REQ-034 With ALU_SEQ_WB_EN, op=0x1 -> w high cycle 3 with reg_we, f cycle 4; reg_we never coincides with e.
